// File: rtl/box_shape_drawer_pkg.sv
// Shared display constants and the drawer state encoding.
package box_shape_drawer_pkg;
  localparam int GRID_W   = 240;
  localparam int GRID_H   = 180;
  localparam int COLOUR_W = 3;
  localparam int COORD_W  = 8;
  // Box dimensions are capped at 64, so 6-bit scan counters suffice.
  localparam int CNT_W    = 6;

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

  // True when a 9-bit pixel position lies on the visible grid.
  function automatic logic in_grid(input logic [COORD_W:0] px, input logic [COORD_W:0] py);
    return (px < (COORD_W+1)'(GRID_W)) && (py < (COORD_W+1)'(GRID_H));
  endfunction
endpackage

// File: rtl/box_scan_counter.sv
// Row-major column/row scan over a BOX_W x BOX_H box with a last-pixel flag.
module box_scan_counter
  import box_shape_drawer_pkg::*;
#(
  parameter int BOX_W = 16,
  parameter int BOX_H = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_col,
  output logic [CNT_W-1:0] o_row,
  output logic             o_last
);
  logic [CNT_W-1:0] r_col, r_row;
  logic             w_col_end, w_row_end;

  assign w_col_end = (r_col == CNT_W'(BOX_W-1));
  assign w_row_end = (r_row == CNT_W'(BOX_H-1));
  assign o_last    = w_col_end && w_row_end;
  assign o_col     = r_col;
  assign o_row     = r_row;

  // Advance column each enabled cycle; wrap to next row at the right edge.
  always_ff @(posedge clock) begin
    if (reset || i_clr) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_en) begin
      if (w_col_end) begin
        r_col <= '0;
        r_row <= w_row_end ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end
endmodule

// File: rtl/box_shape_drawer.sv
// Note-box drawer: latches origin/colour, scans the box one pixel per clock
// into the VGA adapter port, and pulses shapeDone when finished.
module box_shape_drawer
  import box_shape_drawer_pkg::*;
#(
  parameter int BOX_W = 16,
  parameter int BOX_H = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                loadStartAddress,
  input  logic                startingAddressLoaded,
  input  logic [COORD_W-1:0]  boxX,
  input  logic [COORD_W-1:0]  boxY,
  input  logic [COLOUR_W-1:0] boxColour,
  output logic [COORD_W-1:0]  x,
  output logic [COORD_W-1:0]  y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                shapeDone,
  output logic                busy
);
  state_t              r_state, w_next;
  logic [COORD_W-1:0]  r_org_x, r_org_y;
  logic [COLOUR_W-1:0] r_org_c;
  logic [COORD_W-1:0]  r_x, r_y;
  logic [COLOUR_W-1:0] r_colour;
  logic                r_plot, r_done, r_busy;
  logic                w_clr, w_en, w_last;
  logic [CNT_W-1:0]    w_col, w_row;
  logic [COORD_W:0]    w_px, w_py;

  box_scan_counter #(.BOX_W(BOX_W), .BOX_H(BOX_H)) u_scan (
    .clock  (clock),
    .reset  (reset),
    .i_clr  (w_clr),
    .i_en   (w_en),
    .o_col  (w_col),
    .o_row  (w_row),
    .o_last (w_last)
  );

  // 9-bit sums so off-grid pixels are detectable before truncation.
  assign w_px = {1'b0, r_org_x} + {{(COORD_W+1-CNT_W){1'b0}}, w_col};
  assign w_py = {1'b0, r_org_y} + {{(COORD_W+1-CNT_W){1'b0}}, w_row};

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state and counter control; start/load only honoured in IDLE.
  always_comb begin
    w_next = r_state;
    w_clr  = 1'b0;
    w_en   = 1'b0;
    case (r_state)
      S_IDLE: if (startingAddressLoaded) begin
        w_clr  = 1'b1;
        w_next = S_DRAW;
      end
      S_DRAW: begin
        w_en = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Origin/colour latch; a same-cycle start then draws with the new values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_org_x <= '0;
      r_org_y <= '0;
      r_org_c <= '0;
    end else if (r_state == S_IDLE && loadStartAddress) begin
      r_org_x <= boxX;
      r_org_y <= boxY;
      r_org_c <= boxColour;
    end
  end

  // Registered VGA outputs, one cycle behind the scan position.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_x      <= '0;
      r_y      <= '0;
      r_colour <= '0;
      r_plot   <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_plot <= (r_state == S_DRAW) && in_grid(w_px, w_py);
      r_done <= (r_state == S_DONE);
      r_busy <= (r_state != S_IDLE);
      if (r_state == S_DRAW) begin
        r_x      <= w_px[COORD_W-1:0];
        r_y      <= w_py[COORD_W-1:0];
        r_colour <= r_org_c;
      end
    end
  end

  assign x         = r_x;
  assign y         = r_y;
  assign colour    = r_colour;
  assign plot      = r_plot;
  assign shapeDone = r_done;
  assign busy      = r_busy;
endmodule
